// File: rtl/capsense_tracker.sv
// capsense_tracker: times per-pad charge intervals, keeps self-calibrating baselines, debounces touches.
// Define CAPSENSE_TRACKER_RAW_EN to add raw_sel_i/raw_o ({baseline, last count} of one pad).
module capsense_tracker #(
  parameter int N        = 4,
  parameter int CW       = 8,
  parameter int THRESH   = 6,
  parameter int HYST     = 2,
  parameter int DEB      = 3,
  parameter int TRACK_SH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ena_i,
  input  logic                 sense_oe_i,
  input  logic [N-1:0]         pads_i,
  output logic [N-1:0]         touched_o,
  output logic [N-1:0]         press_o,
  output logic [N-1:0]         release_o,
  output logic                 cal_done_o,
  output logic [7:0]           scan_cnt_o
`ifdef CAPSENSE_TRACKER_RAW_EN
  ,
  input  logic [$clog2(N)-1:0] raw_sel_i,
  output logic [2*CW-1:0]      raw_o
`endif
);

  localparam int IW = $clog2(N);
  localparam logic [CW-1:0]       CMAX     = {CW{1'b1}};
  localparam logic [CW-1:0]       CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]       TOUCH_TH = CW'(THRESH);
  localparam logic [CW-1:0]       REL_TH   = CW'(THRESH - HYST);
  localparam logic [3:0]          DEB_C    = 4'(DEB);
  localparam logic [TRACK_SH-1:0] PRE_ONE  = TRACK_SH'(1);
  localparam logic [TRACK_SH-1:0] PRE_LAST = {TRACK_SH{1'b1}};
  localparam logic [IW-1:0]       LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CHARGE = 2'd1, S_EVAL = 2'd2} state_e;

  state_e               state_q;
  logic                 oe_q, pend_q, cal_q;
  logic [IW-1:0]        idx_q;
  logic [7:0]           scan_q;
  logic [N-1:0]         done_q, touched_q, press_q, release_q;
  logic [CW-1:0]        cnt_q  [N];
  logic [CW-1:0]        base_q [N];
  logic [3:0]           deb_q  [N];
  logic [TRACK_SH-1:0]  pre_q  [N];

  logic [CW-1:0]        cnt_d  [N];
  logic [N-1:0]         done_d;
  logic                 fall_s, charge_end_s;
  logic [CW-1:0]        cnt_s, base_s, excess_s, base_step_s;
  logic [CW:0]          diff_s;
  logic                 tch_s, raw_s, track_s;
  logic [3:0]           deb_inc_s;

  // Charge-phase next values and end-of-interval detection
  always_comb begin
    fall_s       = oe_q & ~sense_oe_i;
    charge_end_s = 1'b1;
    for (int i = 0; i < N; i++) begin
      cnt_d[i]  = cnt_q[i];
      done_d[i] = done_q[i];
      if (ena_i && !done_q[i]) begin
        if (pads_i[i]) begin
          done_d[i] = 1'b1;
        end else if (cnt_q[i] != CMAX) begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end else begin
          cnt_d[i] = cnt_q[i];
        end
      end else begin
        done_d[i] = done_q[i];
      end
      charge_end_s = charge_end_s & (done_d[i] | (cnt_d[i] == CMAX));
    end
  end

  // Shared evaluation datapath for the pad selected by idx_q
  always_comb begin
    cnt_s     = cnt_q[idx_q];
    base_s    = base_q[idx_q];
    tch_s     = touched_q[idx_q];
    diff_s    = {1'b0, cnt_s} - {1'b0, base_s};
    excess_s  = diff_s[CW] ? '0 : diff_s[CW-1:0];
    raw_s     = tch_s ? (excess_s >= REL_TH) : (excess_s >= TOUCH_TH);
    track_s   = ~raw_s & ~tch_s;
    deb_inc_s = deb_q[idx_q] + 4'd1;
    if (cnt_s > base_s) begin
      base_step_s = base_s + CNT_ONE;
    end else if (cnt_s < base_s) begin
      base_step_s = base_s - CNT_ONE;
    end else begin
      base_step_s = base_s;
    end
  end

  // Sequencer, per-pad state and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      oe_q      <= 1'b0;
      pend_q    <= 1'b0;
      cal_q     <= 1'b0;
      idx_q     <= '0;
      scan_q    <= 8'd0;
      done_q    <= '0;
      touched_q <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i]  <= '0;
        base_q[i] <= '0;
        deb_q[i]  <= 4'd0;
        pre_q[i]  <= '0;
      end
    end else begin
      oe_q      <= sense_oe_i;
      press_q   <= '0;
      release_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (fall_s) begin
            state_q <= S_CHARGE;
            done_q  <= '0;
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
          end
        end
        S_CHARGE: begin
          idx_q <= '0;
          if (sense_oe_i) begin
            state_q <= S_EVAL;
          end else begin
            done_q <= done_d;
            for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
            if (charge_end_s) state_q <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (fall_s) pend_q <= 1'b1;
          if (!cal_q) begin
            base_q[idx_q] <= cnt_s;
          end else begin
            if (raw_s != tch_s) begin
              if (deb_inc_s == DEB_C) begin
                touched_q[idx_q] <= ~tch_s;
                deb_q[idx_q]     <= 4'd0;
                press_q[idx_q]   <= ~tch_s;
                release_q[idx_q] <= tch_s;
              end else begin
                deb_q[idx_q] <= deb_inc_s;
              end
            end else begin
              deb_q[idx_q] <= 4'd0;
            end
            // Drift prescaler only advances over consecutive quiet scans
            if (track_s) begin
              pre_q[idx_q] <= pre_q[idx_q] + PRE_ONE;
              if (pre_q[idx_q] == PRE_LAST) base_q[idx_q] <= base_step_s;
            end else begin
              pre_q[idx_q] <= '0;
            end
          end
          if (idx_q == LAST_IDX) begin
            idx_q  <= '0;
            scan_q <= scan_q + 8'd1;
            cal_q  <= 1'b1;
            if (pend_q || fall_s) begin
              state_q <= S_CHARGE;
              pend_q  <= 1'b0;
              done_q  <= '0;
              for (int i = 0; i < N; i++) cnt_q[i] <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef CAPSENSE_TRACKER_RAW_EN
  logic [2*CW-1:0] raw_q;

  // Debug readback of the selected pad
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      raw_q <= '0;
    end else begin
      raw_q <= {base_q[raw_sel_i], cnt_q[raw_sel_i]};
    end
  end

  assign raw_o = raw_q;
`endif

  assign touched_o  = touched_q;
  assign press_o    = press_q;
  assign release_o  = release_q;
  assign cal_done_o = cal_q;
  assign scan_cnt_o = scan_q;

endmodule

// File: tb/tb_capsense_tracker.sv
// Randomised bench for capsense_tracker against a per-scan behavioural model.
module tb_capsense_tracker;
  localparam int N = 4;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         ena_i = 1'b0;
  logic         sense_oe_i = 1'b1;
  logic [N-1:0] pads_i = '0;
  logic [N-1:0] touched_o, press_o, release_o;
  logic         cal_done_o;
  logic [7:0]   scan_cnt_o;
`ifdef CAPSENSE_TRACKER_RAW_EN
  logic [1:0]   raw_sel_i = 2'd0;
  logic [15:0]  raw_o;
`endif

  capsense_tracker dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ena_i(ena_i), .sense_oe_i(sense_oe_i),
    .pads_i(pads_i), .touched_o(touched_o), .press_o(press_o),
    .release_o(release_o), .cal_done_o(cal_done_o), .scan_cnt_o(scan_cnt_o)
`ifdef CAPSENSE_TRACKER_RAW_EN
    , .raw_sel_i(raw_sel_i), .raw_o(raw_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_err = 0;
  int base_m[N], tch_m[N], deb_m[N], pre_m[N], cnt_m[N];
  int press_exp[N], rel_exp[N], press_seen[N], rel_seen[N];
  int cal_m = 0, scan_m = 0;
  int tgt[N];
  bit in_chain = 1'b0;

  always @(negedge clk_i) begin
    for (int i = 0; i < N; i++) begin
      if (press_o[i])   press_seen[i]++;
      if (release_o[i]) rel_seen[i]++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      base_m[i] = 0; tch_m[i] = 0; deb_m[i] = 0; pre_m[i] = 0; cnt_m[i] = 0;
    end
    cal_m = 0; scan_m = 0;
  endtask

  // One scan: pad i's count is the number of ena pulses it saw before charging, capped by pulses given and 255
  task automatic model_scan(input int p);
    int c, ex, raw, was;
    for (int i = 0; i < N; i++) begin
      c = tgt[i];
      if (c > p) c = p;
      if (c > 255) c = 255;
      cnt_m[i] = c;
      if (cal_m == 0) begin
        base_m[i] = c;
      end else begin
        ex = c - base_m[i];
        if (ex < 0) ex = 0;
        was = tch_m[i];
        raw = (was != 0) ? int'(ex >= 4) : int'(ex >= 6);
        if (raw != was) begin
          deb_m[i]++;
          if (deb_m[i] == 3) begin
            deb_m[i] = 0;
            tch_m[i] = raw;
            if (raw != 0) press_exp[i]++; else rel_exp[i]++;
          end
        end else begin
          deb_m[i] = 0;
        end
        if (raw == 0 && was == 0) begin
          pre_m[i]++;
          if (pre_m[i] == 16) begin
            pre_m[i] = 0;
            if (c > base_m[i]) base_m[i]++;
            else if (c < base_m[i]) base_m[i]--;
          end
        end else begin
          pre_m[i] = 0;
        end
      end
    end
    cal_m = 1;
    scan_m = (scan_m + 1) % 256;
  endtask

  task automatic check_state(input string tag);
    logic [N-1:0] t;
    for (int i = 0; i < N; i++) t[i] = (tch_m[i] != 0);
    chk({tag, ".touched"}, touched_o, t);
    chk({tag, ".cal_done"}, cal_done_o, 1'b1);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s.press%0d", tag, i), press_seen[i], press_exp[i]);
      chk($sformatf("%s.release%0d", tag, i), rel_seen[i], rel_exp[i]);
    end
`ifdef CAPSENSE_TRACKER_RAW_EN
    raw_sel_i = 2'($urandom_range(0, N - 1));
    cyc(2);
    chk({tag, ".raw"}, raw_o, {8'(base_m[raw_sel_i]), 8'(cnt_m[raw_sel_i])});
`endif
  endtask

  // Drive one charge interval with pad targets tgt[]; abort_at>0 raises sense_oe after that many pulses
  task automatic run_scan(input string tag, input int abort_at, input bit chain);
    int p, mx, t;
    bit ab;
    mx = 0;
    for (int i = 0; i < N; i++) if (tgt[i] > mx) mx = tgt[i];
    p = (mx + 1 > 255) ? 255 : mx + 1;
    ab = 1'b0;
    if (abort_at > 0 && abort_at < p) begin
      p = abort_at;
      ab = 1'b1;
    end
    if (!in_chain) begin
      sense_oe_i = 1'b1; pads_i = '0;
      cyc(3);
      sense_oe_i = 1'b0;
      cyc(2);
    end else begin
      pads_i = '0;
    end
    for (int k = 1; k <= p; k++) begin
      for (int i = 0; i < N; i++) pads_i[i] = (k > tgt[i]);
      ena_i = 1'b1; cyc();
      ena_i = 1'b0; cyc();
    end
    if (ab) begin
      sense_oe_i = 1'b1;
      cyc();
    end else if (chain) begin
      sense_oe_i = 1'b1; cyc();
      sense_oe_i = 1'b0; cyc();
    end
    model_scan(p);
    t = 0;
    while (scan_cnt_o != 8'(scan_m) && t < 200) begin
      cyc();
      t++;
    end
    chk({tag, ".scan_cnt"}, scan_cnt_o, 8'(scan_m));
    cyc(3);
    check_state(tag);
    in_chain = chain && !ab;
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < N; i++) tgt[i] = v;
  endtask

  task automatic reset_mid_charge(input string tag);
    in_chain = 1'b0;
    sense_oe_i = 1'b1; pads_i = '0;
    cyc(3);
    sense_oe_i = 1'b0;
    cyc(2);
    repeat (5) begin
      ena_i = 1'b1; cyc();
      ena_i = 1'b0; cyc();
    end
    rst_ni = 1'b0;
    #1;
    chk({tag, ".touched"}, touched_o, '0);
    chk({tag, ".press"}, press_o, '0);
    chk({tag, ".release"}, release_o, '0);
    chk({tag, ".cal_done"}, cal_done_o, 1'b0);
    chk({tag, ".scan_cnt"}, scan_cnt_o, 8'd0);
    model_reset();
    sense_oe_i = 1'b1;
    cyc(2);
    rst_ni = 1'b1;
    cyc();
  endtask

  initial begin
    model_reset();
    cyc(2);
    chk("rst.touched", touched_o, '0);
    chk("rst.cal_done", cal_done_o, 1'b0);
    chk("rst.scan_cnt", scan_cnt_o, 8'd0);
    chk("rst.pulses", {press_o, release_o}, '0);
    rst_ni = 1'b1;
    cyc();

    reset_mid_charge("rst_early");
    set_all(10); run_scan("cal", 0, 1'b0);
    tgt[2] = 16; run_scan("touch2a", 0, 1'b0); run_scan("touch2b", 0, 1'b0);
    tgt[2] = 10; run_scan("touch_gap", 0, 1'b0);
    tgt[2] = 16; repeat (3) run_scan("touch3", 0, 1'b0);
    tgt[2] = 14; repeat (3) run_scan("hyst_hold", 0, 1'b0);
    tgt[2] = 13; repeat (3) run_scan("hyst_rel", 0, 1'b0);
    set_all(10); tgt[0] = 300; run_scan("sat", 0, 1'b0);
    set_all(20); run_scan("abort", 8, 1'b0);
    set_all(10); run_scan("settle", 0, 1'b1);
    tgt[1] = 12; repeat (32) run_scan("drift", 0, 1'b1);
    tgt[1] = 17; repeat (3) run_scan("drift_probe", 0, 1'b0);

    for (int s = 0; s < 60; s++) begin
      if (s == 40) reset_mid_charge("rst_rand");
      for (int i = 0; i < N; i++) begin
        tgt[i] = base_m[i] + int'($urandom_range(0, 11)) - 2;
        if (tgt[i] < 0) tgt[i] = 0;
        if ($urandom_range(0, 39) == 0) tgt[i] = 300;
      end
      run_scan("rand", ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 12)) : 0,
               $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/capsense_tracker.md
Name: capsense_tracker

Overview:
- Downstream consumer of the capacitive-sense front end. It times each pad's charge interval after the front end releases discharge, and keeps a per-pad self-calibrating baseline.
- It turns charge-time excess over baseline into debounced touch levels plus one-cycle press/release pulses for the LED/UI logic.
- Processes pads serially in an evaluation phase, one pad per clock, sharing one comparator/adder datapath.

Parameters:
N, 4, number of pads
CW, 8, charge-count width; counts saturate at 2^CW-1
THRESH, 6, count excess over baseline that means "touched"
HYST, 2, release threshold = THRESH-HYST (must be < THRESH)
DEB, 3, consecutive agreeing scans before a level changes (1..15)
TRACK_SH, 4, baseline drift step is taken once every 2^TRACK_SH untouched scans

Ports:
clk_i input 1 system clock
rst_ni input 1 asynchronous active-low reset
ena_i input 1 sample strobe (same strobe that paces the front end)
sense_oe_i input 1 front-end discharge enable; 1=discharging, falling edge starts a charge interval
pads_i input N synchronised pad inputs (1 = charged past threshold)
touched_o output N debounced touch level per pad
press_o output N one-cycle pulse on 0->1 of touched_o[i]
release_o output N one-cycle pulse on 1->0 of touched_o[i]
cal_done_o output 1 high once baselines are valid
scan_cnt_o output 8 scans completed, wraps 255->0

Behaviour:
- Reset (async, rst_ni=0) clears all state: touched_o=0, press_o=0, release_o=0, cal_done_o=0, scan_cnt_o=0, counts/baselines/debounce counters=0, FSM=IDLE.
- FSM states IDLE, CHARGE, EVAL.
- IDLE: stays put while sense_oe_i=1. Registered falling edge of sense_oe_i -> CHARGE; per-pad counts and done flags are cleared on entry.
- CHARGE: on each ena_i, for every pad with done=0:
  - if pads_i[i]=1, set done[i];
  - else increment count[i], saturating at 2^CW-1.
- CHARGE -> EVAL when any of the following is true:
  - all done flags set;
  - every undone count is saturated;
  - sense_oe_i returns to 1 (aborted interval). Undone pads keep their current count.
- EVAL: N cycles, pad index 0..N-1, one pad per cycle.
  - First scan after reset (cal_done_o=0): baseline[i]=count[i]. No level evaluation; press_o and release_o stay 0.
  - Otherwise, excess = count - baseline. Compute CW+1 bits signed; a negative excess is treated as 0.
  - Raw touch condition: touched=0 needs excess >= THRESH; touched=1 needs excess >= THRESH-HYST.
  - If raw != touched_o[i], increment deb[i]; otherwise clear deb[i].
  - When deb[i] reaches DEB: toggle touched_o[i], clear deb[i], and pulse press_o[i] or release_o[i] on the next cycle for exactly one clock.
  - Baseline tracking runs only when raw=0 and touched_o[i]=0, every 2^TRACK_SH scans (per-pad prescaler). The baseline steps ±1 toward count; no step if equal.
- After the last pad: scan_cnt_o increments and cal_done_o is set to 1 (it stays set until reset). The FSM then goes to IDLE, or straight to CHARGE if a sense_oe_i falling edge occurred during EVAL (the edge is latched, not lost).
- Simultaneous press on several pads: pulses may land in different cycles (serial EVAL). Each pulse is one clock wide.
- Baseline never wraps: increments clamp at 2^CW-1, decrements clamp at 0.
- ena_i during EVAL or IDLE is ignored.

Optional Feature:
- Macro CAPSENSE_TRACKER_RAW_EN.
- Defined: adds ports raw_sel_i (input, clog2(N)) and raw_o (output, 2*CW). raw_o = {baseline[sel], last count[sel]}, registered, 1-cycle latency, reset 0.
- Undefined: the ports do not exist, and the count registers are still kept internally.

Test Plan:
- Reset mid-CHARGE (rst_ni low after 5 ena_i pulses) -> all outputs 0 immediately; the next scan is the calibration scan again.
- Calibration: pads rise after 10 ena_i -> baselines=10, cal_done_o=1 after EVAL, no press pulses.
- Touch pad2 with count 16 (baseline 10, THRESH=6) for 3 scans -> touched_o=4'b0100 after the third EVAL, single press_o[2] pulse. 2 scans only -> no change.
- Hysteresis: pad2 touched, count 14 (excess 4 = THRESH-HYST) -> stays touched. Count 13 for 3 scans -> release_o[2] pulse, touched_o[2]=0.
- Saturation/abort: pad0 never charges -> count reaches 255, EVAL entered. Separately, sense_oe_i rises mid-CHARGE -> EVAL runs with partial counts, no hang.
- Drift: untouched pad count 12 vs baseline 10 -> baseline reaches 12 after 32 scans (TRACK_SH=4), never overshoots, no press generated.
